// File: rtl/ysyx_24080006_axi_arbiter_pkg.sv
// Shared AXI channel bundles, arbiter state encoding and the grant-selection helper
// used by the IFU/LSU arbiter and its watchdog.
package ysyx_24080006_axi_arbiter_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
        logic [3:0] bid;
    } axi_w_s2m_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_RD_IFU, ARB_RD_LSU, ARB_WR_LSU} arb_state_e;
    typedef enum logic {ARB_MST_IFU, ARB_MST_LSU} arb_master_e;

    localparam axi_r_m2s_t AxiRM2sIdle = '0;
    localparam axi_r_s2m_t AxiRS2mIdle = '0;
    localparam axi_w_m2s_t AxiWM2sIdle = '0;
    localparam axi_w_s2m_t AxiWS2mIdle = '0;

    // Winner when IFU and LSU request together: alternate under round-robin, else LSU.
    function automatic arb_master_e arb_pick(input bit rr_enable, input arb_master_e rr_last);
        if (rr_enable && rr_last == ARB_MST_LSU) return ARB_MST_IFU;
        return ARB_MST_LSU;
    endfunction

endpackage

// File: rtl/ysyx_24080006_arb_watchdog.sv
// Per-transaction watchdog: counts active cycles since the last clear and raises a
// sticky flag once the count reaches TimeoutCycles; TimeoutCycles=0 disables it.
module ysyx_24080006_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned CntW          = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic active,
    output logic timeout_o
);

    localparam bit            Enabled = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (clear)       cnt_q <= '0;
            else if (active) cnt_q <= cnt_q + CntW'(1);
            if (Enabled && active && !clear && cnt_q == Limit) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Shares one downstream AXI4 port between IFU (read bursts) and LSU (single-beat
// reads/writes), one whole transaction at a time, with beat checking and a watchdog.
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_axi_arbiter_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 0,
    parameter bit          RrEnable      = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  axi_r_m2s_t ifu_r_i,
    output axi_r_s2m_t ifu_r_o,
    input  axi_r_m2s_t lsu_r_i,
    output axi_r_s2m_t lsu_r_o,
    input  axi_w_m2s_t lsu_w_i,
    output axi_w_s2m_t lsu_w_o,
    output axi_r_m2s_t mem_r_o,
    input  axi_r_s2m_t mem_r_i,
    output axi_w_m2s_t mem_w_o,
    input  axi_w_s2m_t mem_w_i,
    output logic       busy_o,
    output logic       timeout_o,
    output logic       proto_err_o
);

    arb_state_e  state_q, state_d;
    arb_master_e rr_last_q, winner;
    logic [7:0]  beat_cnt_q, arlen_q;
    logic        ar_done_q, aw_done_q, w_done_q, proto_err_q;
    logic        ifu_req, lsu_rd_req, lsu_wr_req, lsu_req, grant;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ifu_req    = ifu_r_i.arvalid;
    assign lsu_wr_req = lsu_w_i.awvalid;
    assign lsu_rd_req = lsu_r_i.arvalid;
    assign lsu_req    = lsu_wr_req || lsu_rd_req;

    assign ar_hs = mem_r_o.arvalid && mem_r_i.arready;
    assign r_hs  = mem_r_i.rvalid  && mem_r_o.rready;
    assign aw_hs = mem_w_o.awvalid && mem_w_i.awready;
    assign w_hs  = mem_w_o.wvalid  && mem_w_i.wready;
    assign b_hs  = mem_w_i.bvalid  && mem_w_o.bready;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        winner  = ARB_MST_LSU;
        unique case (state_q)
            ARB_IDLE: begin
                if (ifu_req || lsu_req) begin
                    if (ifu_req && lsu_req) winner = arb_pick(RrEnable, rr_last_q);
                    else                    winner = ifu_req ? ARB_MST_IFU : ARB_MST_LSU;
                    if (winner == ARB_MST_IFU) state_d = ARB_RD_IFU;
                    else                       state_d = lsu_wr_req ? ARB_WR_LSU : ARB_RD_LSU;
                end
            end
            ARB_RD_IFU, ARB_RD_LSU: if (r_hs && mem_r_i.rlast) state_d = ARB_IDLE;
            ARB_WR_LSU:             if (b_hs) state_d = ARB_IDLE;
            default:                state_d = ARB_IDLE;
        endcase
    end

    assign grant = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);

    // Routing depends only on registered state and master inputs; done flags hide a
    // master's next request until the current transaction retires.
    always_comb begin
        mem_r_o = AxiRM2sIdle;
        mem_w_o = AxiWM2sIdle;
        ifu_r_o = AxiRS2mIdle;
        lsu_r_o = AxiRS2mIdle;
        lsu_w_o = AxiWS2mIdle;
        unique case (state_q)
            ARB_RD_IFU: begin mem_r_o = ifu_r_i; ifu_r_o = mem_r_i; end
            ARB_RD_LSU: begin mem_r_o = lsu_r_i; lsu_r_o = mem_r_i; end
            ARB_WR_LSU: begin mem_w_o = lsu_w_i; lsu_w_o = mem_w_i; end
            default: ;
        endcase
        if (ar_done_q) begin
            mem_r_o.arvalid = 1'b0;
            ifu_r_o.arready = 1'b0;
            lsu_r_o.arready = 1'b0;
        end
        if (aw_done_q) begin
            mem_w_o.awvalid = 1'b0;
            lsu_w_o.awready = 1'b0;
        end
        if (w_done_q) begin
            mem_w_o.wvalid = 1'b0;
            lsu_w_o.wready = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            rr_last_q   <= ARB_MST_LSU;
            beat_cnt_q  <= '0;
            arlen_q     <= '0;
            ar_done_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) rr_last_q <= winner;
            if (state_q == ARB_IDLE) begin
                beat_cnt_q <= '0;
                ar_done_q  <= 1'b0;
                aw_done_q  <= 1'b0;
                w_done_q   <= 1'b0;
            end else begin
                if (ar_hs) begin
                    ar_done_q <= 1'b1;
                    arlen_q   <= mem_r_o.arlen;
                end
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
                if (r_hs) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                    // Last beat must coincide exactly with beat index arlen.
                    if (mem_r_i.rlast != (beat_cnt_q == arlen_q)) proto_err_q <= 1'b1;
                end
            end
        end
    end

    ysyx_24080006_arb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (grant),
        .active   (busy_o),
        .timeout_o(timeout_o)
    );

    assign busy_o      = (state_q != ARB_IDLE);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: bursts, arbitration order, write routing,
// protocol error, watchdog and asynchronous reset.
module tb_ysyx_24080006_axi_arbiter;
    import ysyx_24080006_axi_arbiter_pkg::*;

    logic       clock;
    logic       reset_n;
    axi_r_m2s_t ifu_r_i, lsu_r_i, mem_r_o, fp_mem_r_o;
    axi_r_s2m_t ifu_r_o, lsu_r_o, mem_r_i, fp_ifu_r_o, fp_lsu_r_o;
    axi_w_m2s_t lsu_w_i, mem_w_o, fp_mem_w_o;
    axi_w_s2m_t lsu_w_o, mem_w_i, fp_lsu_w_o;
    logic       busy_o, timeout_o, proto_err_o;
    logic       fp_busy_o, fp_timeout_o, fp_proto_err_o;

    int vectors     = 0;
    int miscompares = 0;

    ysyx_24080006_axi_arbiter #(.TimeoutCycles(16), .RrEnable(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_r_i(ifu_r_i), .ifu_r_o(ifu_r_o),
        .lsu_r_i(lsu_r_i), .lsu_r_o(lsu_r_o),
        .lsu_w_i(lsu_w_i), .lsu_w_o(lsu_w_o),
        .mem_r_o(mem_r_o), .mem_r_i(mem_r_i),
        .mem_w_o(mem_w_o), .mem_w_i(mem_w_i),
        .busy_o(busy_o), .timeout_o(timeout_o), .proto_err_o(proto_err_o)
    );

    ysyx_24080006_axi_arbiter #(.TimeoutCycles(0), .RrEnable(1'b0)) dut_fp (
        .clock(clock), .reset_n(reset_n),
        .ifu_r_i(ifu_r_i), .ifu_r_o(fp_ifu_r_o),
        .lsu_r_i(lsu_r_i), .lsu_r_o(fp_lsu_r_o),
        .lsu_w_i(lsu_w_i), .lsu_w_o(fp_lsu_w_o),
        .mem_r_o(fp_mem_r_o), .mem_r_i(mem_r_i),
        .mem_w_o(fp_mem_w_o), .mem_w_i(mem_w_i),
        .busy_o(fp_busy_o), .timeout_o(fp_timeout_o), .proto_err_o(fp_proto_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ifu_r_i = '0;
        lsu_r_i = '0;
        lsu_w_i = '0;
        mem_r_i = '0;
        mem_w_i = '0;
        mem_r_i.arready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        do_reset();
        #1;
        chk_bit("rst_busy", busy_o, 1'b0);
        chk_bit("rst_timeout", timeout_o, 1'b0);
        chk_bit("rst_proto", proto_err_o, 1'b0);
        chk_vec("rst_mem_r", 128'(mem_r_o), '0);
        chk_vec("rst_mem_w", 128'(mem_w_o), '0);
        chk_vec("rst_ifu_r", 128'(ifu_r_o), '0);
        chk_vec("rst_lsu_w", 128'(lsu_w_o), '0);

        // 1: IFU 4-beat burst
        ifu_r_i.arvalid = 1'b1;
        ifu_r_i.araddr  = 32'h8000_0040;
        ifu_r_i.arlen   = 8'd3;
        ifu_r_i.rready  = 1'b1;
        #1;
        chk_bit("t1_idle_no_arready", ifu_r_o.arready, 1'b0);
        chk_bit("t1_idle_no_mem_arvalid", mem_r_o.arvalid, 1'b0);
        tick(); #1;
        chk_bit("t1_busy", busy_o, 1'b1);
        chk_bit("t1_mem_arvalid", mem_r_o.arvalid, 1'b1);
        chk_vec("t1_mem_araddr", 128'(mem_r_o.araddr), 128'(32'h8000_0040));
        chk_bit("t1_ifu_arready", ifu_r_o.arready, 1'b1);
        tick();
        ifu_r_i.arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_r_i.rvalid = 1'b1;
            mem_r_i.rdata  = 32'hA0 + 32'(b);
            mem_r_i.rlast  = (b == 3);
            #1;
            chk_vec("t1_ifu_rdata", 128'(ifu_r_o.rdata), 128'(32'hA0 + 32'(b)));
            chk_bit("t1_ifu_rlast", ifu_r_o.rlast, (b == 3));
            chk_bit("t1_lsu_muted", lsu_r_o.rvalid, 1'b0);
            tick();
        end
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t1_idle_after", busy_o, 1'b0);
        chk_bit("t1_proto_ok", proto_err_o, 1'b0);

        // 2: simultaneous IFU and LSU reads after reset
        do_reset();
        ifu_r_i.arvalid = 1'b1;
        ifu_r_i.araddr  = 32'h8000_1000;
        ifu_r_i.rready  = 1'b1;
        lsu_r_i.arvalid = 1'b1;
        lsu_r_i.araddr  = 32'h2000_0008;
        lsu_r_i.rready  = 1'b1;
        tick(); #1;
        chk_bit("t2_rr_ifu_first", ifu_r_o.arready, 1'b1);
        chk_bit("t2_rr_lsu_wait", lsu_r_o.arready, 1'b0);
        chk_vec("t2_rr_araddr_ifu", 128'(mem_r_o.araddr), 128'(32'h8000_1000));
        chk_bit("t2_fp_lsu_first", fp_lsu_r_o.arready, 1'b1);
        chk_bit("t2_fp_ifu_wait", fp_ifu_r_o.arready, 1'b0);
        chk_vec("t2_fp_araddr_lsu", 128'(fp_mem_r_o.araddr), 128'(32'h2000_0008));
        tick();
        mem_r_i.rvalid = 1'b1;
        mem_r_i.rlast  = 1'b1;
        mem_r_i.rdata  = 32'h1111_2222;
        #1;
        chk_bit("t2_ifu_rvalid", ifu_r_o.rvalid, 1'b1);
        chk_bit("t2_ar_masked_after_hs", mem_r_o.arvalid, 1'b0);
        tick();
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t2_idle_gap", busy_o, 1'b0);
        tick(); #1;
        chk_bit("t2_rr_lsu_next", lsu_r_o.arready, 1'b1);
        chk_bit("t2_rr_ifu_held", ifu_r_o.arready, 1'b0);
        chk_vec("t2_rr_araddr_lsu", 128'(mem_r_o.araddr), 128'(32'h2000_0008));
        tick();
        lsu_r_i.arvalid = 1'b0;
        ifu_r_i.arvalid = 1'b0;
        mem_r_i.rvalid  = 1'b1;
        mem_r_i.rlast   = 1'b1;
        mem_r_i.rdata   = 32'h3333_4444;
        #1;
        chk_vec("t2_lsu_rdata", 128'(lsu_r_o.rdata), 128'(32'h3333_4444));
        tick();
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t2_done", busy_o, 1'b0);

        // 3: LSU write, awready two cycles after wready, IFU waiting
        lsu_w_i.awvalid = 1'b1;
        lsu_w_i.awaddr  = 32'h2000_0100;
        lsu_w_i.wvalid  = 1'b1;
        lsu_w_i.wdata   = 32'hDEAD_BEEF;
        lsu_w_i.wstrb   = 4'hF;
        lsu_w_i.wlast   = 1'b1;
        lsu_w_i.bready  = 1'b1;
        tick();
        ifu_r_i.arvalid = 1'b1;
        ifu_r_i.araddr  = 32'h8000_2000;
        mem_w_i.wready  = 1'b1;
        #1;
        chk_bit("t3_mem_wvalid", mem_w_o.wvalid, 1'b1);
        chk_vec("t3_mem_wdata", 128'(mem_w_o.wdata), 128'(32'hDEAD_BEEF));
        chk_bit("t3_lsu_wready", lsu_w_o.wready, 1'b1);
        chk_bit("t3_lsu_awready0", lsu_w_o.awready, 1'b0);
        chk_bit("t3_ifu_blocked_a", ifu_r_o.arready, 1'b0);
        chk_bit("t3_mem_r_muted", mem_r_o.arvalid, 1'b0);
        tick();
        lsu_w_i.wvalid = 1'b0;
        mem_w_i.wready = 1'b0;
        #1;
        chk_bit("t3_ifu_blocked_b", ifu_r_o.arready, 1'b0);
        tick();
        mem_w_i.awready = 1'b1;
        #1;
        chk_bit("t3_lsu_awready", lsu_w_o.awready, 1'b1);
        chk_vec("t3_mem_awaddr", 128'(mem_w_o.awaddr), 128'(32'h2000_0100));
        tick();
        lsu_w_i.awvalid = 1'b0;
        mem_w_i.awready = 1'b0;
        mem_w_i.bvalid  = 1'b1;
        #1;
        chk_bit("t3_lsu_bvalid", lsu_w_o.bvalid, 1'b1);
        chk_bit("t3_ifu_blocked_c", ifu_r_o.arready, 1'b0);
        chk_bit("t3_busy_wr", busy_o, 1'b1);
        tick();
        mem_w_i.bvalid = 1'b0;
        lsu_w_i.bready = 1'b0;
        #1;
        chk_bit("t3_single_bvalid", lsu_w_o.bvalid, 1'b0);
        chk_bit("t3_idle_after_b", busy_o, 1'b0);
        chk_bit("t3_ifu_blocked_idle", ifu_r_o.arready, 1'b0);
        tick(); #1;
        chk_bit("t3_ifu_granted", ifu_r_o.arready, 1'b1);
        tick();
        ifu_r_i.arvalid = 1'b0;
        mem_r_i.rvalid  = 1'b1;
        mem_r_i.rlast   = 1'b1;
        tick();
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t3_ifu_done", busy_o, 1'b0);

        // 4: arlen=1 but rlast on the first beat
        ifu_r_i.arvalid = 1'b1;
        ifu_r_i.arlen   = 8'd1;
        tick();
        tick();
        ifu_r_i.arvalid = 1'b0;
        mem_r_i.rvalid  = 1'b1;
        mem_r_i.rlast   = 1'b1;
        #1;
        chk_bit("t4_proto_before", proto_err_o, 1'b0);
        tick();
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t4_proto_set", proto_err_o, 1'b1);
        chk_bit("t4_exit_idle", busy_o, 1'b0);
        tick();
        tick(); #1;
        chk_bit("t4_proto_sticky", proto_err_o, 1'b1);
        chk_bit("t4_no_timeout", timeout_o, 1'b0);

        // 5: watchdog with mem never accepting AR
        do_reset();
        #1;
        chk_bit("t5_proto_cleared", proto_err_o, 1'b0);
        mem_r_i.arready = 1'b0;
        lsu_r_i.arvalid = 1'b1;
        lsu_r_i.araddr  = 32'h2000_0200;
        lsu_r_i.rready  = 1'b1;
        tick();
        repeat (15) tick();
        #1;
        chk_bit("t5_no_timeout_15", timeout_o, 1'b0);
        chk_bit("t5_busy_15", busy_o, 1'b1);
        tick(); #1;
        chk_bit("t5_timeout_16", timeout_o, 1'b1);
        chk_bit("t5_busy_16", busy_o, 1'b1);
        chk_bit("t5_no_abort", mem_r_o.arvalid, 1'b1);

        // 6: asynchronous reset mid-burst, then a fresh LSU read
        do_reset();
        #1;
        chk_bit("t6_timeout_cleared", timeout_o, 1'b0);
        ifu_r_i.arvalid = 1'b1;
        ifu_r_i.araddr  = 32'h8000_3000;
        ifu_r_i.arlen   = 8'd3;
        ifu_r_i.rready  = 1'b1;
        tick();
        tick();
        ifu_r_i.arvalid = 1'b0;
        mem_r_i.rvalid  = 1'b1;
        mem_r_i.rdata   = 32'hC0;
        tick();
        mem_r_i.rdata = 32'hC1;
        #1;
        chk_vec("t6_beat2_rdata", 128'(ifu_r_o.rdata), 128'(32'hC1));
        #1;
        reset_n = 1'b0;
        #1;
        chk_bit("t6_async_busy", busy_o, 1'b0);
        chk_vec("t6_async_ifu_r", 128'(ifu_r_o), '0);
        chk_vec("t6_async_mem_r", 128'(mem_r_o), '0);
        chk_bit("t6_async_proto", proto_err_o, 1'b0);
        do_reset();
        lsu_r_i.arvalid = 1'b1;
        lsu_r_i.araddr  = 32'h2000_0300;
        lsu_r_i.rready  = 1'b1;
        tick(); #1;
        chk_bit("t6_lsu_arready", lsu_r_o.arready, 1'b1);
        tick();
        lsu_r_i.arvalid = 1'b0;
        mem_r_i.rvalid  = 1'b1;
        mem_r_i.rlast   = 1'b1;
        mem_r_i.rdata   = 32'h5A5A_0001;
        #1;
        chk_vec("t6_lsu_rdata", 128'(lsu_r_o.rdata), 128'(32'h5A5A_0001));
        chk_bit("t6_lsu_rlast", lsu_r_o.rlast, 1'b1);
        tick();
        mem_r_i.rvalid = 1'b0;
        mem_r_i.rlast  = 1'b0;
        #1;
        chk_bit("t6_done", busy_o, 1'b0);
        chk_bit("t6_proto_ok", proto_err_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
